// File: rtl/mem_io_ctrl_pkg.sv
// Shared definitions for the memory/IO controller.
// Holds the request-type codes, the address map, the FSM state codes and the
// address-region decode helper.
package mem_io_ctrl_pkg;

  typedef enum logic [3:0] {
    MODE_NONE = 4'd0,
    MODE_LW   = 4'd1,
    MODE_SW   = 4'd2,
    MODE_LB   = 4'd3,
    MODE_LBU  = 4'd4,
    MODE_SB   = 4'd5
  } io_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SRAM_SETUP  = 3'd1,
    ST_SRAM_STROBE = 3'd2,
    ST_UART_WAIT   = 3'd3,
    ST_DONE        = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REG_SRAM      = 2'd0,
    REG_UART_DATA = 2'd1,
    REG_UART_STAT = 2'd2,
    REG_UNMAPPED  = 2'd3
  } region_e;

  localparam logic [31:0] SRAM_BASE      = 32'h8000_0000;
  localparam logic [31:0] SRAM_MASK      = 32'hFFC0_0000;  // 4 MiB window
  localparam logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8;
  localparam logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC;

  function automatic region_e addr_region(input logic [31:0] addr);
    if ((addr & SRAM_MASK) == SRAM_BASE) return REG_SRAM;
    else if (addr == UART_DATA_ADDR)     return REG_UART_DATA;
    else if (addr == UART_STAT_ADDR)     return REG_UART_STAT;
    else                                 return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/mem_io_ctrl_lane.sv
// mem_lane_sel: byte-lane extraction and extension for SRAM reads.
// Ports:
//   i_word [31:0]  raw word from the SRAM
//   i_lane [1:0]   byte lane (byte address bits [1:0])
//   i_mode [3:0]   request type; LB sign-extends, LBU zero-extends,
//                  anything else passes the word through
//   o_data [31:0]  extended read data
module mem_lane_sel
  import mem_io_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [3:0]  i_mode,
  output logic [31:0] o_data
);

  logic [7:0] w_byte;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  always_comb begin
    o_data = i_word;
    if (i_mode == MODE_LB)
      o_data = {{24{w_byte[7]}}, w_byte};
    else if (i_mode == MODE_LBU)
      o_data = {24'b0, w_byte};
  end

endmodule

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: bridges a simple CPU IO request port to an asynchronous SRAM
// and a byte-wide UART.
// Ports:
//   clk, rst                 clock, async active-high reset
//   io_mode/io_addr/io_wdata request (held stable by the master until io_ready)
//   io_rdata, io_ready       read data (held until next read) and done pulse
//   sram_*                   SRAM address, data, strobes and byte enables
//   uart_*                   UART tx handshake and rx data/acknowledge
//
// state          | meaning
// ST_IDLE        | waiting for io_mode != NONE
// ST_SRAM_SETUP  | chip enable, address and byte enables settle
// ST_SRAM_STROBE | oe_n/we_n asserted for WAIT_CYCLES cycles
// ST_UART_WAIT   | UART/unmapped decode; UART tx holds here while busy
// ST_DONE        | io_ready pulse, write data still driven
module mem_io_ctrl
  import mem_io_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  io_mode,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        io_ready,
  output logic [19:0] sram_addr,
  output logic [31:0] sram_dout,
  output logic        sram_doe,
  input  logic [31:0] sram_din,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_start,
  input  logic        uart_tx_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ack
);

  state_e      r_state;
  state_e      w_next;
  logic [3:0]  r_wait;
  logic [31:0] r_rdata;

  region_e     w_region;
  logic        w_rd;
  logic        w_wr;
  logic        w_byte;
  logic        w_uart_tx;
  logic [3:0]  w_be_n;
  logic [31:0] w_lane_data;
  logic [31:0] w_uart_rdata;
  logic        w_strobe_last;

  // Request fields are read straight from the port: the master keeps them
  // stable until io_ready, so no request register is needed.
  assign w_region  = addr_region(io_addr);
  assign w_rd      = (io_mode == MODE_LW) || (io_mode == MODE_LB) || (io_mode == MODE_LBU);
  assign w_wr      = (io_mode == MODE_SW) || (io_mode == MODE_SB);
  assign w_byte    = (io_mode == MODE_LB) || (io_mode == MODE_LBU) || (io_mode == MODE_SB);
  assign w_uart_tx = w_wr && (w_region == REG_UART_DATA);
  assign w_be_n    = w_byte ? ~(4'b0001 << io_addr[1:0]) : 4'b0000;

  assign sram_addr     = io_addr[21:2];
  assign sram_dout     = (io_mode == MODE_SB) ? {4{io_wdata[7:0]}} : io_wdata;
  assign uart_tx_data  = io_wdata[7:0];
  assign io_rdata      = r_rdata;
  assign w_strobe_last = (r_state == ST_SRAM_STROBE) && (r_wait == 4'd0);

  mem_lane_sel u_lane_sel (
    .i_word (sram_din),
    .i_lane (io_addr[1:0]),
    .i_mode (io_mode),
    .o_data (w_lane_data)
  );

  always_comb begin
    w_uart_rdata = 32'b0;
    if (w_region == REG_UART_DATA)
      w_uart_rdata = {24'b0, uart_rx_data};
    else if (w_region == REG_UART_STAT)
      w_uart_rdata = {30'b0, uart_rx_valid, ~uart_tx_busy};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wait  <= 4'd0;
      r_rdata <= 32'b0;
    end else begin
      r_state <= w_next;
      // Strobe length is a down-counter; zero marks the last strobe cycle.
      if (r_state == ST_SRAM_SETUP)
        r_wait <= 4'(WAIT_CYCLES - 1);
      else if ((r_state == ST_SRAM_STROBE) && (r_wait != 4'd0))
        r_wait <= r_wait - 4'd1;
      if (w_strobe_last && w_rd)
        r_rdata <= w_lane_data;
      else if ((r_state == ST_UART_WAIT) && w_rd)
        r_rdata <= w_uart_rdata;
    end
  end

  // Strobes are decoded from the state register so that reset removes them
  // in the same cycle it is asserted.
  always_comb begin
    w_next        = r_state;
    io_ready      = 1'b0;
    sram_ce_n     = 1'b1;
    sram_oe_n     = 1'b1;
    sram_we_n     = 1'b1;
    sram_be_n     = 4'hF;
    sram_doe      = 1'b0;
    uart_tx_start = 1'b0;
    uart_rx_ack   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rd || w_wr)
          w_next = (w_region == REG_SRAM) ? ST_SRAM_SETUP : ST_UART_WAIT;
      end
      ST_SRAM_SETUP: begin
        sram_ce_n = 1'b0;
        sram_be_n = w_be_n;
        sram_doe  = w_wr;
        w_next    = ST_SRAM_STROBE;
      end
      ST_SRAM_STROBE: begin
        sram_ce_n = 1'b0;
        sram_be_n = w_be_n;
        sram_oe_n = ~w_rd;
        sram_we_n = ~w_wr;
        sram_doe  = w_wr;
        if (r_wait == 4'd0)
          w_next = ST_DONE;
      end
      ST_UART_WAIT: begin
        if (w_uart_tx) begin
          if (!uart_tx_busy) begin
            uart_tx_start = 1'b1;
            w_next        = ST_DONE;
          end
        end else begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        io_ready    = 1'b1;
        // Write data held one cycle past the we_n rise.
        sram_doe    = w_wr && (w_region == REG_SRAM);
        uart_rx_ack = w_rd && (w_region == REG_UART_DATA) && uart_rx_valid;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
module tb_mem_io_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  io_mode = 4'd0;
  logic [31:0] io_addr = 32'd0;
  logic [31:0] io_wdata = 32'd0;
  logic [31:0] io_rdata;
  logic        io_ready;
  logic [19:0] sram_addr;
  logic [31:0] sram_dout;
  logic        sram_doe;
  logic [31:0] sram_din = 32'd0;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy = 1'b0;
  logic [7:0]  uart_rx_data = 8'd0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ack;

  always #5 clk = ~clk;

  mem_io_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .io_mode(io_mode), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ready(io_ready),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe),
    .sram_din(sram_din), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
    .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
    .uart_tx_busy(uart_tx_busy), .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid), .uart_rx_ack(uart_rx_ack)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // region: 0 SRAM, 1 UART data, 2 UART status, 3 unmapped
  function automatic int model_region(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h803F_FFFF) return 0;
    if (a == 32'hBFD0_03F8) return 1;
    if (a == 32'hBFD0_03FC) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] m, input logic [31:0] a,
      input logic [31:0] din, input logic busy, input logic [7:0] rxd, input logic rxv);
    int rg;
    int b;
    rg = model_region(a);
    if (rg == 1) return {24'd0, rxd};
    if (rg == 2) return (rxv ? 32'd2 : 32'd0) + (busy ? 32'd0 : 32'd1);
    if (rg == 3) return 32'd0;
    b = int'((din >> (8 * int'(a[1:0]))) & 32'hFF);
    if (m == 4'd1) return din;
    if (m == 4'd3) return (b >= 128) ? 32'(b - 256) : 32'(b);
    return 32'(b);
  endfunction

  // Current transaction as seen by the compare process.
  bit          t_active = 0;
  int          t_k = 0;
  logic [3:0]  t_mode;
  logic [31:0] t_addr, t_wdata, t_rdata_exp;
  bit          t_rd, t_wr, t_uw, t_rxv;
  int          t_region, t_busy_b, t_ready_k;
  logic [31:0] m_last_rdata = 32'd0;

  // Observations collected for the hand-computed checks.
  int          obs_ready_k, obs_we_cnt, obs_tx_cnt, obs_tx_k;
  logic [3:0]  obs_be;
  logic [31:0] obs_dout;
  logic [7:0]  obs_tx_data;

  always @(negedge clk) begin
    int   k;
    logic e_ce, e_oe, e_we, e_doe, e_rdy, e_tx, e_ack, is_byte;
    logic [3:0]  e_be;
    logic [31:0] e_dout, e_rdata;
    if (t_active && !rst) begin
      k = t_k;
      if (k == 0) begin
        obs_ready_k = -1; obs_we_cnt = 0; obs_tx_cnt = 0; obs_tx_k = -1;
        obs_be = 4'hF; obs_dout = 32'd0; obs_tx_data = 8'd0;
      end
      if (io_ready === 1'b1 && obs_ready_k < 0) obs_ready_k = k;
      if (sram_we_n === 1'b0) begin
        obs_we_cnt++; obs_be = sram_be_n; obs_dout = sram_dout;
      end
      if (uart_tx_start === 1'b1) begin
        obs_tx_cnt++; obs_tx_k = k; obs_tx_data = uart_tx_data;
      end

      e_rdy = (k == t_ready_k);
      e_ce  = (t_region == 0) && k >= 1 && k <= W + 1;
      e_oe  = e_ce && k >= 2 && t_rd;
      e_we  = e_ce && k >= 2 && t_wr;
      e_doe = (t_region == 0) && t_wr && k >= 1 && k <= W + 2;
      e_tx  = t_uw && (k == t_busy_b + 1);
      e_ack = (t_region == 1) && t_rd && t_rxv && e_rdy;
      e_rdata = (t_rd && k >= t_ready_k) ? t_rdata_exp : m_last_rdata;
      is_byte = (t_mode == 4'd3) || (t_mode == 4'd4) || (t_mode == 4'd5);
      for (int i = 0; i < 4; i++)
        e_be[i] = is_byte ? (i != int'(t_addr[1:0])) : 1'b0;
      e_dout = (t_mode == 4'd5) ? (32'(t_wdata[7:0]) * 32'h0101_0101) : t_wdata;

      chk("io_ready", 32'(io_ready), 32'(e_rdy));
      chk("sram_ce_n", 32'(sram_ce_n), 32'(!e_ce));
      chk("sram_oe_n", 32'(sram_oe_n), 32'(!e_oe));
      chk("sram_we_n", 32'(sram_we_n), 32'(!e_we));
      chk("sram_doe", 32'(sram_doe), 32'(e_doe));
      chk("uart_tx_start", 32'(uart_tx_start), 32'(e_tx));
      chk("uart_rx_ack", 32'(uart_rx_ack), 32'(e_ack));
      chk("io_rdata", io_rdata, e_rdata);
      if (e_ce) begin
        chk("sram_be_n", 32'(sram_be_n), 32'(e_be));
        chk("sram_addr", 32'(sram_addr), (t_addr >> 2) & 32'h000F_FFFF);
      end
      if (e_doe) chk("sram_dout", sram_dout, e_dout);
      if (e_tx)  chk("uart_tx_data", 32'(uart_tx_data), 32'(t_wdata[7:0]));
    end
  end

  // Runs one request; busy_b = UART tx busy cycles (data writes), busy_c =
  // constant busy level otherwise.
  task automatic run_txn(input logic [3:0] mode, input logic [31:0] addr,
      input logic [31:0] wdata, input logic [31:0] din, input int busy_b,
      input logic busy_c, input logic [7:0] rxd, input logic rxv);
    @(posedge clk); #1;
    io_mode = mode; io_addr = addr; io_wdata = wdata; sram_din = din;
    uart_rx_data = rxd; uart_rx_valid = rxv;
    t_mode = mode; t_addr = addr; t_wdata = wdata; t_rxv = rxv;
    t_rd = (mode == 4'd1) || (mode == 4'd3) || (mode == 4'd4);
    t_wr = (mode == 4'd2) || (mode == 4'd5);
    t_region = model_region(addr);
    t_uw = (t_region == 1) && t_wr;
    t_busy_b = busy_b;
    uart_tx_busy = t_uw ? 1'b0 : busy_c;
    t_ready_k = (t_region == 0) ? W + 2 : (t_uw ? busy_b + 2 : 2);
    t_rdata_exp = model_read(mode, addr, din, busy_c, rxd, rxv);
    t_k = 0;
    t_active = 1;
    while (t_k < t_ready_k + 1) begin
      @(posedge clk); #1;
      t_k++;
      if (t_uw) uart_tx_busy = (t_k >= 1 && t_k <= busy_b);
      if (t_k == t_ready_k + 1) io_mode = 4'd0;
    end
    @(posedge clk); #1;
    if (t_rd) m_last_rdata = t_rdata_exp;
    t_active = 0;
  endtask

  task automatic idle_txn(input logic [3:0] mode);
    @(posedge clk); #1;
    io_mode = mode; io_addr = 32'h8000_0000 | ($urandom & 32'h003F_FFFF);
    repeat (3) begin
      @(negedge clk);
      chk("none_io_ready", 32'(io_ready), 32'd0);
      chk("none_ce_n", 32'(sram_ce_n), 32'd1);
    end
    #1 io_mode = 4'd0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_io_ready", 32'(io_ready), 32'd0);
    chk("rst_io_rdata", io_rdata, 32'd0);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_be_n", 32'(sram_be_n), 32'hF);
    chk("rst_doe", 32'(sram_doe), 32'd0);
    chk("rst_tx_start", 32'(uart_tx_start), 32'd0);
    chk("rst_rx_ack", 32'(uart_rx_ack), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed scenarios pinning the model.
    run_txn(4'd1, 32'h8000_0010, 32'd0, 32'h1234_5678, 0, 1'b0, 8'd0, 1'b0);
    chk("lw_sram_rdata", io_rdata, 32'h1234_5678);
    chk("lw_sram_latency", 32'(obs_ready_k), 32'd4);
    run_txn(4'd5, 32'h8000_0003, 32'h0000_00AB, 32'd0, 0, 1'b0, 8'd0, 1'b0);
    chk("sb_we_cycles", 32'(obs_we_cnt), 32'd2);
    chk("sb_be_n", 32'(obs_be), 32'h7);
    chk("sb_dout", obs_dout, 32'hABAB_ABAB);
    run_txn(4'd3, 32'h8000_0002, 32'd0, 32'h0080_0000, 0, 1'b0, 8'd0, 1'b0);
    chk("lb_rdata", io_rdata, 32'hFFFF_FF80);
    run_txn(4'd4, 32'h8000_0002, 32'd0, 32'h0080_0000, 0, 1'b0, 8'd0, 1'b0);
    chk("lbu_rdata", io_rdata, 32'h0000_0080);
    run_txn(4'd2, 32'hBFD0_03F8, 32'h0000_0041, 32'd0, 5, 1'b0, 8'd0, 1'b0);
    chk("uart_tx_pulses", 32'(obs_tx_cnt), 32'd1);
    chk("uart_tx_cycle", 32'(obs_tx_k), 32'd6);
    chk("uart_tx_byte", 32'(obs_tx_data), 32'h41);
    chk("uart_tx_ready", 32'(obs_ready_k), 32'd7);
    run_txn(4'd1, 32'hBFD0_03FC, 32'd0, 32'd0, 0, 1'b0, 8'd0, 1'b1);
    chk("uart_stat_rdata", io_rdata, 32'h3);
    run_txn(4'd1, 32'hBFD0_03F8, 32'd0, 32'd0, 0, 1'b0, 8'h5A, 1'b1);
    chk("uart_rx_rdata", io_rdata, 32'h5A);
    run_txn(4'd1, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 0, 1'b0, 8'd0, 1'b0);
    chk("unmapped_rdata", io_rdata, 32'd0);
    chk("unmapped_latency", 32'(obs_ready_k), 32'd2);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      int sel;
      logic [31:0] a;
      logic [31:0] edge_addr [5];
      edge_addr[0] = 32'h803F_FFFC; edge_addr[1] = 32'h8040_0000;
      edge_addr[2] = 32'h7FFF_FFFC; edge_addr[3] = 32'hBFD0_03F4;
      edge_addr[4] = 32'hBFD0_0400;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3, 4: a = 32'h8000_0000 | ($urandom & 32'h003F_FFFF);
        5: a = 32'hBFD0_03F8;
        6: a = 32'hBFD0_03FC;
        7: a = $urandom & 32'h7FFF_FFFF;
        default: a = edge_addr[$urandom_range(0, 4)];
      endcase
      if (sel == 9)
        idle_txn(($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(6, 15)));
      else
        run_txn(4'($urandom_range(1, 5)), a, $urandom, $urandom,
                int'($urandom_range(0, 4)), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    // Reset during the write strobe aborts the access.
    @(posedge clk); #1;
    io_mode = 4'd2; io_addr = 32'h8000_0100; io_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_we_before", 32'(sram_we_n), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_doe", 32'(sram_doe), 32'd0);
    chk("abort_ce_n", 32'(sram_ce_n), 32'd1);
    chk("abort_be_n", 32'(sram_be_n), 32'hF);
    chk("abort_io_ready", 32'(io_ready), 32'd0);
    chk("abort_io_rdata", io_rdata, 32'd0);
    io_mode = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_last_rdata = 32'd0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_ready", 32'(io_ready), 32'd0);
    end
    run_txn(4'd1, 32'h8000_0100, 32'd0, 32'h0BAD_CAFE, 0, 1'b0, 8'd0, 1'b0);
    chk("post_abort_rdata", io_rdata, 32'h0BAD_CAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, SRAM access strobe length in clk cycles (legal 1..15).
REQ-002 SHALL have port clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have io_mode  in  4  request type; io_addr  in  32  byte address; io_wdata  in  32  write data.
REQ-004 SHALL have io_rdata  out  32  read data; io_ready  out  1  one-cycle completion pulse.
REQ-005 SHALL have sram_addr  out  20  word address; sram_dout  out  32; sram_doe  out  1  data drive enable; sram_din  in  32.
REQ-006 SHALL have sram_ce_n, sram_oe_n, sram_we_n  out  1 each; sram_be_n  out  4  byte enables, active-low.
REQ-007 SHALL have uart_tx_data  out  8; uart_tx_start  out  1; uart_tx_busy  in  1; uart_rx_data  in  8; uart_rx_valid  in  1; uart_rx_ack  out  1.

Function
REQ-008 io_mode encoding SHALL be: 0 NONE, 1 LW, 2 SW, 3 LB (sign-extend), 4 LBU (zero-extend), 5 SB; codes 6-15 treated as NONE.
REQ-009 Address map SHALL be: 0x80000000-0x803FFFFF SRAM (sram_addr = io_addr[21:2]); 0xBFD003F8 UART data; 0xBFD003FC UART status; all else unmapped.
REQ-010 FSM states SHALL be IDLE, SRAM_SETUP, SRAM_STROBE, UART_WAIT, DONE.
REQ-011 IDLE: io_mode != NONE SHALL start a request next cycle; master holds io_mode/io_addr/io_wdata stable until io_ready.
REQ-012 SRAM access: SRAM_SETUP 1 cycle (ce_n=0, addr/be valid), then SRAM_STROBE exactly WAIT_CYCLES cycles (oe_n=0 for reads, we_n=0 for writes), then DONE.
REQ-013 SRAM read data SHALL be captured on the last SRAM_STROBE cycle; total latency request-to-io_ready = WAIT_CYCLES+2 cycles.
REQ-014 Word accesses SHALL ignore io_addr[1:0]; LW/SW assert all be_n low.
REQ-015 SB SHALL drive io_wdata[7:0] replicated on all four lanes with only be_n[io_addr[1:0]] low.
REQ-016 LB/LBU SHALL select lane io_addr[1:0] of sram_din and sign/zero-extend to 32 bits.
REQ-017 sram_doe SHALL be 1 from SRAM_SETUP through DONE for writes only, ensuring data hold one cycle past we_n rise.
REQ-018 UART data write SHALL wait in UART_WAIT while uart_tx_busy=1, then pulse uart_tx_start one cycle with uart_tx_data=io_wdata[7:0], then DONE.
REQ-019 UART data read SHALL return {24'b0, uart_rx_data} and pulse uart_rx_ack one cycle in DONE only if uart_rx_valid=1.
REQ-020 UART status read SHALL return {30'b0, uart_rx_valid, ~uart_tx_busy}; status write ignored.
REQ-021 Unmapped reads SHALL return 0, unmapped writes discarded; both complete in 2 cycles.
REQ-022 DONE SHALL last one cycle with io_ready=1, then return to IDLE; io_rdata SHALL hold last read value until next read completes.
REQ-023 A request held after io_ready SHALL be treated as a new request (master deasserts io_mode for one cycle between accesses).

Reset
REQ-024 rst SHALL immediately force IDLE, io_rdata=0, io_ready=0, sram_ce_n/oe_n/we_n=1, sram_be_n=4'hF, sram_doe=0, uart_tx_start=0, uart_rx_ack=0.
REQ-025 rst mid-access SHALL abort without completing; no io_ready pulse SHALL be produced for the aborted request.

Structure
REQ-026 io_mode codes, address-map bases/masks and FSM state codes SHALL live in the shared defs package.
REQ-027 Byte-lane extraction/extension SHALL be one combinational sub-module, mem_lane_sel.

Verification
REQ-028 LW 0x80000010 with sram_din=0x12345678, WAIT_CYCLES=2 -> oe_n low cycles 2-3, io_ready cycle 4, io_rdata=0x12345678.
REQ-029 SB 0x80000003, io_wdata=0xAB -> sram_be_n=4'b0111, sram_dout=0xABABABAB, we_n low exactly 2 cycles.
REQ-030 LB 0x80000002 with sram_din=0x00800000 -> io_rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-031 SW 0xBFD003F8 data 0x41 with tx_busy=1 for 5 cycles -> single tx_start pulse after busy falls, tx_data=0x41, then io_ready.
REQ-032 LW 0xBFD003FC with rx_valid=1, tx_busy=0 -> io_rdata=0x3; LW 0x00001000 -> io_rdata=0, io_ready in 2 cycles.
REQ-033 rst asserted during SRAM_STROBE of a write -> we_n=1, doe=0 same cycle, no io_ready.
